// File: rtl/pipelined_rca_addsub.sv
// pipelined_rca_addsub: WIDTH-bit ripple-carry adder/subtractor. The carry
// chain is cut into STAGES registered segments of CHUNK full adders each.
// Results come out one per clock, STAGES cycles after the operands are
// accepted. Valid/ready handshakes sit on both the input and output sides.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/ready   operand handshake (in_ready = !out_valid || out_ready)
//   a, b, c_in, sub  operands; sub=1 computes a - b - c_in (c_in = borrow-in)
//   out_valid/ready  result handshake
//   sum, c_out, ovf  result, carry out of MSB, signed overflow
//
// WIDTH must be a nonzero multiple of STAGES.
module pipelined_rca_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // One pipeline slot. The operand fields carry the not-yet-added high bits
  // forward. s accumulates finished chunks. cy is the carry out of the
  // latest chunk.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cy;
    logic [WIDTH-1:0] s;
    logic             ovf;
  } stage_t;

  logic advance;

  // The whole pipe moves together whenever the tail slot can be vacated.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned BASE = k * CHUNK;

    stage_t src_c;
    stage_t stg_d;
    stage_t stg_q;

    // Slot feeding this stage: the raw operand bundle for stage 0, else the
    // previous stage register. Subtraction is folded into b and the carry
    // here.
    if (k == 0) begin : g_head
      always_comb begin
        src_c     = '0;
        src_c.vld = in_valid;
        src_c.a   = a;
        src_c.b   = b ^ {WIDTH{sub}};
        src_c.cy  = c_in ^ sub;
      end
    end else begin : g_body
      assign src_c = g_stage[k-1].stg_q;
    end

    // Ripple this stage's CHUNK full adders over bits [BASE +: CHUNK].
    always_comb begin
      logic             cy;
      logic             cy_msb;
      logic [IDX_W-1:0] idx;
      stg_d  = stg_q;
      cy     = src_c.cy;
      cy_msb = 1'b0;
      idx    = '0;
      if (advance) begin
        stg_d = src_c;
        for (int unsigned i = 0; i < CHUNK; i++) begin
          idx            = IDX_W'(BASE + i);
          stg_d.s[idx]   = src_c.a[idx] ^ src_c.b[idx] ^ cy;
          cy_msb         = cy;
          cy             = (src_c.a[idx] & src_c.b[idx]) |
                           (cy & (src_c.a[idx] ^ src_c.b[idx]));
        end
        stg_d.cy  = cy;
        // Only the last chunk sees the MSB, so only it can flag overflow.
        stg_d.ovf = (k == STAGES - 1) ? (cy_msb ^ cy) : 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        stg_q <= '0;
      end else begin
        stg_q <= stg_d;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].stg_q.vld;
  assign sum       = g_stage[STAGES-1].stg_q.s;
  assign c_out     = g_stage[STAGES-1].stg_q.cy;
  assign ovf       = g_stage[STAGES-1].stg_q.ovf;

  // Operand skew is dead once the final chunk has been added.
  logic unused_tail;
  assign unused_tail = ^{g_stage[STAGES-1].stg_q.a, g_stage[STAGES-1].stg_q.b};

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// Bench for pipelined_rca_addsub. Covers a 16-bit/4-stage instance and a
// 1-bit/1-stage instance. The expected result of each accepted operand
// bundle is queued. Each result is checked against the head of the queue
// when the DUT hands it over.
module tb_pipelined_rca_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv16, ir16, ov16, or16, ci16, sub16, co16, ovf16;
  logic [15:0] a16, b16, s16;
  logic        iv1, ir1, ov1, or1, ci1, sub1, co1, ovf1;
  logic [0:0]  a1, b1, s1;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_out16 = 0;
  logic [17:0] q16[$];
  logic [17:0] q1[$];
  logic [17:0] e16, e1;

  pipelined_rca_addsub #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .c_in(ci16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
    .c_out(co16), .ovf(ovf16)
  );

  pipelined_rca_addsub #(.WIDTH(1), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .c_in(ci1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1),
    .c_out(co1), .ovf(ovf1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {ovf, c_out, sum} for a w-bit add/sub (w <= 16).
  function automatic logic [17:0] model(input int unsigned w, input logic [15:0] a,
                                        input logic [15:0] b, input logic ci, input logic su);
    logic [16:0] m, ae, be, f;
    logic        am, bm, sm, co;
    m  = (17'd1 << w) - 17'd1;
    ae = {1'b0, a} & m;
    be = {1'b0, (su ? ~b : b)} & m;
    f  = ae + be + 17'(ci ^ su);
    am = |((ae >> (w - 1)) & 17'd1);
    bm = |((be >> (w - 1)) & 17'd1);
    sm = |(((f & m) >> (w - 1)) & 17'd1);
    co = |((f >> w) & 17'd1);
    return {(am == bm) && (sm != am), co, f[15:0] & m[15:0]};
  endfunction

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic su);
    bit acc = 0;
    iv16 = 1'b1; a16 = a; b16 = b; ci16 = ci; sub16 = su;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ir16) begin acc = 1; break; end
    end
    if (acc) begin
      q16.push_back(model(32'd16, a, b, ci, su));
      @(posedge clk); #1;
    end else begin
      check("accept_timeout16", 64'(ir16), 64'd1);
    end
    iv16 = 1'b0;
  endtask

  task automatic op1(input logic a, input logic b, input logic ci);
    bit acc = 0;
    iv1 = 1'b1; a1 = a; b1 = b; ci1 = ci; sub1 = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ir1) begin acc = 1; break; end
    end
    if (acc) begin
      q1.push_back(model(32'd1, {15'd0, a}, {15'd0, b}, ci, 1'b0));
      @(posedge clk); #1;
    end else begin
      check("accept_timeout1", 64'(ir1), 64'd1);
    end
    iv1 = 1'b0;
  endtask

  // Called just after the accept edge on an empty pipe: valid after 3 more edges.
  task automatic lat16();
    check("lat16_e0", 64'(ov16), 64'd0);
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk); #1;
      check($sformatf("lat16_e%0d", j), 64'(ov16), 64'(j == 3));
    end
  endtask

  task automatic drain16();
    for (int t = 0; t < 200; t++) begin
      if (q16.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain16", 64'(q16.size()), 64'd0);
  endtask

  // Output monitors: results are consumed at the edge following this negedge.
  always @(negedge clk) begin
    if (!rst && ov16) begin
      if (!or16) begin
        check("stall_in_ready16", 64'(ir16), 64'd0);
        if (q16.size() == 0) check("stall_unexpected16", 64'(ov16), 64'd0);
        else check("stall_hold16", 64'({ovf16, co16, s16}), 64'(q16[0]));
      end else if (q16.size() == 0) begin
        check("unexpected_out16", 64'(ov16), 64'd0);
      end else begin
        e16 = q16.pop_front();
        check("res16", 64'({ovf16, co16, s16}), 64'(e16));
        n_out16++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov1 && or1) begin
      if (q1.size() == 0) begin
        check("unexpected_out1", 64'(ov1), 64'd0);
      end else begin
        e1 = q1.pop_front();
        check("res1", 64'({ovf1, co1, 15'd0, s1}), 64'(e1));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] v3;
    rst = 1'b1; iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; ci16 = 1'b0; sub16 = 1'b0;
    iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; ci1 = 1'b0; sub1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid16", 64'(ov16), 64'd0);
    check("rst_sum16", 64'(s16), 64'd0);
    check("rst_c_out16", 64'(co16), 64'd0);
    check("rst_ovf16", 64'(ovf16), 64'd0);
    check("rst_out_valid1", 64'(ov1), 64'd0);
    rst = 1'b0;
    check("rst_in_ready16", 64'(ir16), 64'd1);

    // Basic add with latency measurement
    op16(16'h00FF, 16'h0001, 1'b0, 1'b0);
    lat16();
    drain16();

    // Carry out and signed overflow
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drain16();

    // Subtract with and without borrow-in
    op16(16'h0005, 16'h0007, 1'b0, 1'b1);
    op16(16'h0007, 16'h0005, 1'b1, 1'b1);
    drain16();

    // Back-to-back stream with a 3-cycle output stall
    n_out16 = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          op16(16'(i * 16'h1111 + 3), 16'(i * 16'h0F0F), i[0], i[1]);
      end
      begin
        repeat (5) @(posedge clk);
        #1 or16 = 1'b0;
        repeat (3) @(posedge clk);
        #1 or16 = 1'b1;
      end
    join
    drain16();
    check("stream_count16", 64'(n_out16), 64'd8);

    // Random operands with random backpressure
    fork
      begin
        for (int i = 0; i < 24; i++)
          op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1 or16 = 1'($urandom_range(0, 1));
        end
        or16 = 1'b1;
      end
    join
    or16 = 1'b1;
    drain16();

    // Reset with operations in flight
    for (int i = 0; i < 3; i++) op16(16'h1000 + 16'(i), 16'h0001, 1'b0, 1'b0);
    rst = 1'b1; iv16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555;
    @(posedge clk); #1;
    rst = 1'b0; iv16 = 1'b0;
    q16.delete();
    q1.delete();
    check("midrst_out_valid16", 64'(ov16), 64'd0);
    check("midrst_sum16", 64'(s16), 64'd0);
    check("midrst_in_ready16", 64'(ir16), 64'd1);
    repeat (8) @(posedge clk);
    #1;
    check("midrst_idle16", 64'(ov16), 64'd0);
    op16(16'h1234, 16'h4321, 1'b1, 1'b0);
    lat16();
    drain16();

    // Single full adder: whole truth table, latency 1
    for (int v = 0; v < 8; v++) begin
      v3 = 3'(v);
      op1(v3[2], v3[1], v3[0]);
      check($sformatf("lat1_%0d", v), 64'(ov1), 64'd1);
    end
    @(posedge clk); #1;
    check("drain1", 64'(q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
